// File: rtl/traffic_normal_mode.sv
// traffic_normal_mode: two-lane signal sequencer with 1 s prescaler and shadowed durations.
// Optional IDLE_FLASH_EN: flashing yellow on both lanes while idle instead of steady red.
module traffic_normal_mode #(
  parameter int TICK_DIV   = 50000000,
  parameter int DEF_GREEN  = 25,
  parameter int DEF_YELLOW = 5,
  parameter int DEF_RED    = 30,
  parameter int MAX_TIME   = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] greenTime,
  input  logic [6:0] yellowTime,
  input  logic [6:0] redTime,
  output logic [2:0] light1,
  output logic [2:0] light2,
  output logic [6:0] timeLane1,
  output logic [6:0] timeLane2,
  output logic [2:0] state,
  output logic       tick
);
  typedef enum logic [2:0] {IDLE = 3'd0, G1R2 = 3'd1, Y1R2 = 3'd2, R1G2 = 3'd3, R1Y2 = 3'd4} state_t;
  localparam logic [2:0] LR = 3'b100, LY = 3'b010, LG = 3'b001;
`ifdef IDLE_FLASH_EN
  localparam bit FLASH = 1'b1;
`else
  localparam bit FLASH = 1'b0;
`endif
  localparam logic [2:0] IDLE_LAMP = FLASH ? LY : LR;
  state_t state_q, state_d;
  logic [2:0] light1_q, light1_d, light2_q, light2_d, flash_nxt;
  logic [6:0] time1_q, time1_d, time2_q, time2_d;
  logic [6:0] g_q, g_d, y_q, y_d, r_q, r_d, eg, ey, er;
  logic [31:0] cnt_q, cnt_d;
  logic active, tick_w, valid, ending_one, enter;
  assign active = state_q inside {G1R2, Y1R2, R1G2, R1Y2};
  assign tick_w = (active || FLASH) && cnt_q == 32'(TICK_DIV - 1);
  assign valid = greenTime != 7'd0 && yellowTime != 7'd0 &&
                 {1'b0, greenTime} + {1'b0, yellowTime} == {1'b0, redTime} && redTime <= 7'(MAX_TIME);
  assign eg = valid ? greenTime : 7'(DEF_GREEN);
  assign ey = valid ? yellowTime : 7'(DEF_YELLOW);
  assign er = valid ? redTime : 7'(DEF_RED);
  assign ending_one = (state_q == G1R2 || state_q == Y1R2) ? time1_q == 7'd1 : time2_q == 7'd1;
  assign flash_nxt = tick_w ? (light1_q == LY ? 3'b000 : LY) : light1_q;
  assign enter = enable && (state_q == IDLE || (state_q == R1Y2 && tick_w && ending_one));
  always_comb begin
    state_d = state_q;
    light1_d = light1_q;
    light2_d = light2_q;
    time1_d = time1_q;
    time2_d = time2_q;
    g_d = g_q;
    y_d = y_q;
    r_d = r_q;
    cnt_d = (active || FLASH) ? (tick_w ? 32'd0 : cnt_q + 32'd1) : 32'd0;
    if (state_q == IDLE && !enable) begin
      time1_d = '0;
      time2_d = '0;
      light1_d = FLASH ? flash_nxt : LR;
      light2_d = FLASH ? flash_nxt : LR;
    end else if (!active || !enable) begin
      state_d = IDLE;
      time1_d = '0;
      time2_d = '0;
      cnt_d = '0;
      light1_d = IDLE_LAMP;
      light2_d = IDLE_LAMP;
    end else if (tick_w && !ending_one) begin
      time1_d = time1_q - 7'd1;
      time2_d = time2_q - 7'd1;
    end else if (tick_w && state_q == G1R2) begin
      state_d = Y1R2;
      light1_d = LY;
      time1_d = y_q;
      time2_d = time2_q - 7'd1;
    end else if (tick_w && state_q == Y1R2) begin
      state_d = R1G2;
      light1_d = LR;
      light2_d = LG;
      time1_d = r_q;
      time2_d = g_q;
    end else if (tick_w && state_q == R1G2) begin
      state_d = R1Y2;
      light2_d = LY;
      time2_d = y_q;
      time1_d = time1_q - 7'd1;
    end
    // Shadow latch happens only here, so input edits mid-cycle wait for the next green entry
    if (enter) begin
      state_d = G1R2;
      light1_d = LG;
      light2_d = LR;
      g_d = eg;
      y_d = ey;
      r_d = er;
      time1_d = eg;
      time2_d = er;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      light1_q <= LR;
      light2_q <= LR;
      time1_q <= '0;
      time2_q <= '0;
      cnt_q <= '0;
      g_q <= 7'(DEF_GREEN);
      y_q <= 7'(DEF_YELLOW);
      r_q <= 7'(DEF_RED);
    end else begin
      state_q <= state_d;
      light1_q <= light1_d;
      light2_q <= light2_d;
      time1_q <= time1_d;
      time2_q <= time2_d;
      cnt_q <= cnt_d;
      g_q <= g_d;
      y_q <= y_d;
      r_q <= r_d;
    end
  assign state = state_q;
  assign light1 = light1_q;
  assign light2 = light2_q;
  assign timeLane1 = time1_q;
  assign timeLane2 = time2_q;
  assign tick = tick_w;
endmodule

// File: tb/tb_traffic_normal_mode.sv
// tb_traffic_normal_mode: directed and randomized checks against a seconds-based schedule model.
module tb_traffic_normal_mode;
  logic clk = 1'b0, reset, enable, tick;
  logic [6:0] gt, yt, rt, t1, t2;
  logic [2:0] l1, l2, st;
  int passed = 0, total = 0;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
`ifdef IDLE_FLASH_EN
  localparam logic [2:0] IDLE_L = Y;
`else
  localparam logic [2:0] IDLE_L = R;
`endif

  traffic_normal_mode #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .greenTime(gt), .yellowTime(yt), .redTime(rt),
    .light1(l1), .light2(l2), .timeLane1(t1), .timeLane2(t2), .state(st), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  // Schedule expressed as seconds elapsed s since green entry, cycle length 2*(g+y)
  task automatic model(input int s, input int g, input int y);
    chk("state", st, s < g ? 1 : s < g + y ? 2 : s < 2 * g + y ? 3 : 4);
    chk("light1", l1, s < g ? G : s < g + y ? Y : R);
    chk("light2", l2, s < g + y ? R : s < 2 * g + y ? G : Y);
    chk("time1", t1, s < g ? g - s : s < g + y ? g + y - s : 2 * (g + y) - s);
    chk("time2", t2, s < g + y ? g + y - s : s < 2 * g + y ? 2 * g + y - s : 2 * (g + y) - s);
  endtask

  task automatic step_sec();
    repeat (3) @(posedge clk);
    #1 chk("tick_hi", tick, 1);
    @(posedge clk);
    #1 chk("tick_lo", tick, 0);
  endtask

  task automatic run(input int g, input int y, input int s0, input int n);
    for (int s = s0; s < s0 + n; s++) begin
      model(s, g, y);
      step_sec();
    end
  endtask

  task automatic eff(input int g, input int y, input int r, output int eg, output int ey);
    bit ok;
    ok = g >= 1 && y >= 1 && r == g + y && r <= 99;
    eg = ok ? g : 25;
    ey = ok ? y : 5;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, st, 0);
    chk({tag, "_l1"}, l1, R);
    chk({tag, "_l2"}, l2, R);
    chk({tag, "_t1"}, t1, 0);
    chk({tag, "_t2"}, t2, 0);
    chk({tag, "_tick"}, tick, 0);
  endtask

  task automatic rand_cfg(output int g, output int y, output int r);
    g = $urandom_range(1, 8);
    y = $urandom_range(1, 4);
    r = g + y + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    if ($urandom_range(0, 7) == 0) begin
      g = 60;
      y = 40;
      r = 100;
    end
  endtask

  initial begin
    int g, y, r, eg, ey, g2, y2, r2, eg2, ey2, k, len;
    reset = 1'b1;
    enable = 1'b0;
    gt = 7'd3; yt = 7'd2; rt = 7'd5;
    repeat (2) @(posedge clk);
    #1 chk_reset("rst");
    reset = 1'b0;
    @(posedge clk);
    #1 chk("idle_hold", st, 0);
    enable = 1'b1;
    @(posedge clk);
    #1 run(3, 2, 0, 6);
    gt = 7'd4; yt = 7'd1; rt = 7'd5;
    run(3, 2, 6, 4);
    gt = 7'd3; yt = 7'd2; rt = 7'd6;
    run(4, 1, 0, 4);
    model(4, 4, 1);
    repeat (3) @(posedge clk);
    #1 chk("tick_y1r2", tick, 1);
    enable = 1'b0;
    @(posedge clk);
    #1 chk("dis_state", st, 0);
    chk("dis_l1", l1, IDLE_L);
    chk("dis_l2", l2, IDLE_L);
    chk("dis_t1", t1, 0);
    chk("dis_t2", t2, 0);
    chk("dis_tick", tick, 0);
    enable = 1'b1;
    @(posedge clk);
    #1 run(25, 5, 0, 1);
    gt = 7'd4; yt = 7'd1; rt = 7'd5;
    run(25, 5, 1, 59);
    run(4, 1, 0, 9);
    model(9, 4, 1);
    #3 reset = 1'b1;
    #1 chk_reset("async");
    for (int it = 0; it < 6; it++) begin
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      rand_cfg(g, y, r);
      gt = 7'(g); yt = 7'(y); rt = 7'(r);
      @(posedge clk);
      #1 eff(g, y, r, eg, ey);
      len = 2 * (eg + ey);
      k = $urandom_range(0, len - 1);
      run(eg, ey, 0, k);
      rand_cfg(g2, y2, r2);
      gt = 7'(g2); yt = 7'(y2); rt = 7'(r2);
      run(eg, ey, k, len - k);
      eff(g2, y2, r2, eg2, ey2);
      run(eg2, ey2, 0, 2 * (eg2 + ey2));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/traffic_normal_mode.md
Name: traffic_normal_mode

Overview:
- Run-time two-lane signal sequencer that sits directly downstream of the configuration-mode block.
- Consumes the confirmed green/yellow/red durations and drives per-lane lamp outputs and per-lane countdown values.
- Active while configuration mode is inactive (enable=1). It idles when enable=0.
- Generates its own 1 s tick from the system clock.

Parameters:
- TICK_DIV, 50000000: clk cycles per 1 s tick; the bench overrides it to a small value.
- DEF_GREEN, 25: fallback green time in seconds, used when the inputs are invalid.
- DEF_YELLOW, 5: fallback yellow time in seconds.
- DEF_RED, 30: fallback red time in seconds; must equal DEF_GREEN+DEF_YELLOW.
- MAX_TIME, 99: largest legal duration.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- enable  in  1  1 = normal operation, 0 = idle (configuration mode owns the display).
- greenTime  in  7  confirmed green duration in seconds.
- yellowTime  in  7  confirmed yellow duration in seconds.
- redTime  in  7  confirmed red duration in seconds.
- light1  out  3  lane-1 lamps, one-hot {R,Y,G}.
- light2  out  3  lane-2 lamps, one-hot {R,Y,G}.
- timeLane1  out  7  lane-1 seconds remaining in its current colour.
- timeLane2  out  7  lane-2 seconds remaining in its current colour.
- state  out  3  current phase code.
- tick  out  1  one-clk pulse marking each 1 s boundary.

Behaviour:
- Reset values:
  - state=IDLE(0); light1=light2=3'b100 (red).
  - timeLane1=timeLane2=0; tick=0; prescaler=0.
  - Shadow g/y/r registers = DEF_*.
- States: IDLE=0, G1R2=1, Y1R2=2, R1G2=3, R1Y2=4. Codes 5-7 go to IDLE on the next clk.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in non-IDLE states.
  - tick=1 in the cycle the count equals TICK_DIV-1; the count then wraps to 0.
  - Held at 0 in IDLE.
- Entry to G1R2 (from IDLE when enable=1, or from R1Y2 at end of phase):
  - Latch inputs into the shadow registers if valid.
  - Valid means: green>=1, yellow>=1, red==green+yellow, red<=MAX_TIME.
  - If invalid, latch DEF_*.
  - In the same edge: timeLane1=shadow green, timeLane2=shadow red.
  - Input changes at any other time have no effect until the next G1R2 entry.
- IDLE -> G1R2 latency: one clk after enable is sampled high. The first tick follows TICK_DIV clks later.
- On tick in the active phases, the "ending lane" is lane1 in G1R2/Y1R2 and lane2 in R1G2/R1Y2:
  - If the ending lane's timer is 1, the phase advances:
    - G1R2->Y1R2: lane1 loads Y; lane2 decrements.
    - Y1R2->R1G2: lane1 loads R; lane2 loads G.
    - R1G2->R1Y2: lane2 loads Y; lane1 decrements.
    - R1Y2->G1R2: entry rule above.
  - Otherwise both timers decrement by 1.
  - Timers never go below 1 in active states, so the displayed sequence is N..1.
- Lamps per state:
  - G1R2: light1=G, light2=R.
  - Y1R2: light1=Y, light2=R.
  - R1G2: light1=R, light2=G.
  - R1Y2: light1=R, light2=Y.
  - Lamps are registered and change in the same edge as state.
- enable=0 in any active state: IDLE on the next clk, regardless of tick (enable wins over tick). Timers go to 0, prescaler clears, lamps take the idle value.
- Reset mid-phase: immediate return to the reset values; the shadow registers revert to DEF_*.
- All arithmetic is 7-bit unsigned; no wrap occurs because timers are ≥1 before any decrement.

Optional Feature:
- Macro: IDLE_FLASH_EN.
- Defined: in IDLE the prescaler keeps running.
  - light1 and light2 both show Y, toggling between 3'b010 and 3'b000 on every tick.
  - They start lit on IDLE entry.
  - Timers stay 0.
- Not defined: IDLE shows steady red on both lanes, and the prescaler is held at 0.

Test Plan:
- TICK_DIV=4; reset, enable=1 with g/y/r=3/2/5:
  - Expect G1R2 with timeLane1/2=3/5.
  - After 3 ticks expect Y1R2 with 2/2; after 2 more ticks, R1G2 with 5/3.
  - After 3 more ticks, R1Y2 with 2/2; after 2 more ticks, G1R2 with 3/5.
- Invalid config g/y/r=3/2/6, enable=1 -> G1R2 with timeLane1=25, timeLane2=30; a later valid 4/1/5 is applied only at the next G1R2 entry.
- Inputs changed to 4/1/5 in the middle of R1G2 -> the current cycle finishes with 3/2/5; the next G1R2 shows 4/5.
- enable dropped on the same clk as a tick in Y1R2 -> next clk state=IDLE, lamps red/red, timers 0, prescaler 0. Re-raising enable gives G1R2 one clk later.
- Reset asserted asynchronously between clk edges in R1Y2 -> outputs take their reset values before the next edge.
- With IDLE_FLASH_EN, enable=0, TICK_DIV=4 -> both lanes show 010,000,010 changing at every tick boundary. Without the macro -> steady 100.
